inst_encoder: RTL

RV32 instruction encoder: the write-side counterpart of the instruction decoder. It takes decoded-format fields through a valid/ready handshake and packs them into 32-bit RV32 instruction words. Supported types are R-type ALU, I-type ALU-immediate, U-type LUI and CSRRW. Encoded words are buffered in a small FIFO and handed to instruction memory loaders or testbench program builders through a second valid/ready port.

---
 rtl/inst_encoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_encoder: packs RV32 R/I/U/CSRRW fields into words, FIFO out.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module inst_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               inst_type,
   input  logic [6:0]               funct7,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [4:0]               rd,
   input  logic [2:0]               funct3,
   input  logic [11:0]              immI,
   input  logic [19:0]              immU,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         enc_count,
   output logic [CNT_W-1:0]         illegal_count,
   output logic                     err_illegal
);

   localparam int                 c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W+1)'(DEPTH);
   localparam logic [6:0]         c_OP_R    = 7'b0110011;
   localparam logic [6:0]         c_OP_I    = 7'b0010011;
   localparam logic [6:0]         c_OP_LUI  = 7'b0110111;
   localparam logic [6:0]         c_OP_SYS  = 7'b1110011;

   logic [31:0]          r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_PTR_W:0]     r_count;
   logic [CNT_W-1:0]     r_enc_count;
   logic [CNT_W-1:0]     r_ill_count;
   logic                 r_err;

   logic [31:0]          w_word;
   logic                 w_legal;
   logic                 w_push;
   logic                 w_wr;
   logic                 w_pop;

   always_comb begin
      w_word  = 32'h0;
      w_legal = 1'b1;
      case (inst_type)
         3'd0:    w_word = {funct7, rs2, rs1, funct3, rd, c_OP_R};
         3'd1:    w_word = {immI, rs1, funct3, rd, c_OP_I};
         3'd2:    w_word = {immU, rd, c_OP_LUI};
         3'd3:    w_word = {immI, rs1, 3'b001, rd, c_OP_SYS};
         default: w_legal = 1'b0;
      endcase
   end

   // Illegal requests still complete the handshake; they just never reach the FIFO.
   assign in_ready      = !rst && (r_count < c_DEPTH) && !flush;
   assign w_push        = in_valid && in_ready;
   assign w_wr          = w_push && w_legal;
   assign w_pop         = out_valid && out_ready && !flush;

   assign out_valid     = (r_count != '0);
   assign out_inst      = out_valid ? r_mem[r_rptr] : 32'h0;
   assign fifo_count    = r_count;
   assign enc_count     = r_enc_count;
   assign illegal_count = r_ill_count;
   assign err_illegal   = r_err;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= w_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_enc_count <= '0;
         r_ill_count <= '0;
         r_err       <= 1'b0;
      end else begin
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_wr) begin
               r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_wr, w_pop})
               2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
               2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
               default: r_count <= r_count;
            endcase
         end
         if (w_wr) begin
            r_enc_count <= r_enc_count + CNT_W'(1);
         end
         if (w_push && !w_legal) begin
            r_ill_count <= r_ill_count + CNT_W'(1);
            r_err       <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
